// File: rtl/mem_req_arbiter.sv
// Shares one memory port between IF and MEM with fixed data priority,
// a request lock, and an in-order owner FIFO that routes responses back.
module mem_req_arbiter #(
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata,
   output logic        err_spurious
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;

   state_t           state;
   logic [DEPTH-1:0] owner;
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;
   logic             gnt_i;
   logic             gnt_d;
   logic             push;
   logic             pop;
   logic             head;

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // A held grant ignores the other requester until it is accepted.
   always_comb begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
      unique case (state)
         IDLE: begin
            if (!full) begin
               if (data_req)      gnt_d = 1'b1;
               else if (inst_req) gnt_i = 1'b1;
            end
         end
         HOLD_I:  gnt_i = inst_req;
         HOLD_D:  gnt_d = data_req;
         default: ;
      endcase
   end

   assign mem_req   = (gnt_i | gnt_d) & ~full & ~reset;
   assign mem_wr    = gnt_d ? data_wr    : (gnt_i ? inst_wr    : 1'b0);
   assign mem_size  = gnt_d ? data_size  : (gnt_i ? inst_size  : 2'b0);
   assign mem_addr  = gnt_d ? data_addr  : (gnt_i ? inst_addr  : 32'b0);
   assign mem_wstrb = gnt_d ? data_wstrb : (gnt_i ? inst_wstrb : 4'b0);
   assign mem_wdata = gnt_d ? data_wdata : (gnt_i ? inst_wdata : 32'b0);

   assign push = mem_req & mem_addr_ok;
   assign pop  = mem_data_ok & ~empty & ~reset;
   assign head = owner[rptr];

   assign inst_addr_ok = push & gnt_i;
   assign data_addr_ok = push & gnt_d;
   assign inst_data_ok = pop & ~head;
   assign data_data_ok = pop & head;
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         owner        <= '0;
         wptr         <= '0;
         rptr         <= '0;
         count        <= '0;
         err_spurious <= 1'b0;
      end else begin
         if (mem_req && !mem_addr_ok)
            state <= gnt_d ? HOLD_D : HOLD_I;
         else
            state <= IDLE;
         if (push) begin
            owner[wptr] <= gnt_d;
            wptr        <= nxt(wptr);
         end
         if (pop)
            rptr <= nxt(rptr);
         count <= count + CW'(push) - CW'(pop);
         if (mem_data_ok && empty)
            err_spurious <= 1'b1;
      end
   end

endmodule
